// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, flag-index and FSM-state constants for the ALU issue stage.
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 2**AW x DW register file, two async read ports, one sync write port.
module alu_regfile #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (rst) mem <= '{default: '0};
    else if (we) mem[wa] <= wd;
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issue/writeback stage feeding an external 4-bit ALU; IDLE -> EXEC -> RESP.
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          cmd_use_imm,
  input  logic [DW-1:0] cmd_imm,
  input  logic          cmd_flag_we,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_sel,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_k,
  input  logic          alu_n,
  input  logic          alu_c,
  input  logic          alu_v,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [3:0]    rsp_flags,
  output logic [3:0]    flags_q
);
  state_t state;
  logic [AW-1:0] rd_q;
  logic fwe_q;
  logic [DW-1:0] rd1, rd2;
  logic [3:0] alu_f;
  always_comb begin
    alu_f = '0;
    alu_f[FLAG_Z] = alu_k;
    alu_f[FLAG_N] = alu_n;
    alu_f[FLAG_C] = alu_c;
    alu_f[FLAG_V] = alu_v;
  end
  assign cmd_ready = state == ST_IDLE;
  alu_regfile #(.DW(DW), .AW(AW)) u_rf (
    .clk(clk), .rst(rst), .we(state == ST_EXEC), .wa(rd_q), .wd(alu_y),
    .ra1(cmd_rs1), .rd1(rd1), .ra2(cmd_rs2), .rd2(rd2)
  );
  // The ALU operand outputs double as the operand latches, so they hold outside EXEC.
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      rd_q <= '0;
      fwe_q <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_flags <= '0;
      flags_q <= '0;
    end else if (state == ST_IDLE && cmd_valid) begin
      alu_a <= rd1;
      alu_b <= cmd_use_imm ? cmd_imm : rd2;
      alu_sel <= cmd_op;
      rd_q <= cmd_rd;
      fwe_q <= cmd_flag_we;
      state <= ST_EXEC;
    end else if (state == ST_EXEC) begin
      rsp_data <= alu_y;
      rsp_flags <= alu_f;
      if (fwe_q) flags_q <= alu_f;
      rsp_valid <= 1'b1;
      state <= ST_RESP;
    end else if (state == ST_RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      state <= ST_IDLE;
    end
endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: directed + random commands against a register/flag reference model.
module tb_alu_issue_wb;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_use_imm = 0, cmd_flag_we = 0;
  logic [1:0] cmd_op = 0, cmd_rd = 0, cmd_rs1 = 0, cmd_rs2 = 0, alu_sel;
  logic [3:0] cmd_imm = 0, alu_a, alu_b, alu_y, rsp_data, rsp_flags, flags_q;
  logic alu_k, alu_n, alu_c, alu_v, rsp_valid, rsp_ready = 1;
  logic [4:0] t;
  int total = 0, bad = 0;
  int m_reg [4];
  int m_flags;
  always #5 clk = ~clk;
  alu_issue_wb dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_use_imm(cmd_use_imm),
    .cmd_imm(cmd_imm), .cmd_flag_we(cmd_flag_we), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_y(alu_y), .alu_k(alu_k), .alu_n(alu_n), .alu_c(alu_c),
    .alu_v(alu_v), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .flags_q(flags_q)
  );
  // Stand-in for the parent-level ALU.
  always_comb begin
    t = alu_sel == 2'b01 ? {1'b0, alu_a} - {1'b0, alu_b} : {1'b0, alu_a} + {1'b0, alu_b};
    alu_y = alu_sel[1] ? (alu_sel[0] ? alu_a | alu_b : alu_a & alu_b) : t[3:0];
    alu_c = !alu_sel[1] && t[4];
    alu_v = !alu_sel[1] && (alu_sel[0] ? (alu_a[3] != alu_b[3]) : (alu_a[3] == alu_b[3]))
            && (alu_y[3] != alu_a[3]);
    alu_k = alu_y == 0;
    alu_n = alu_y[3];
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic ref_alu(input int op, input int a, input int b, output int y, output int f);
    int sa, sb, r, sr, c, v;
    sa = a > 7 ? a - 16 : a;
    sb = b > 7 ? b - 16 : b;
    c = 0; v = 0;
    if (op == 0) begin r = a + b; sr = sa + sb; c = r > 15; v = sr > 7 || sr < -8; end
    else if (op == 1) begin r = a - b; sr = sa - sb; c = a < b; v = sr > 7 || sr < -8; end
    else if (op == 2) r = a & b;
    else r = a | b;
    y = (r + 16) % 16;
    f = (y == 0) * 8 + (y >= 8) * 4 + c * 2 + v;
  endtask
  task automatic run(input int op, rd, rs1, rs2, ui, imm, fwe, h);
    int a, b, ey, ef;
    logic [3:0] hd;
    a = m_reg[rs1];
    b = ui ? imm : m_reg[rs2];
    ref_alu(op, a, b, ey, ef);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_op = 2'(op); cmd_rd = 2'(rd); cmd_rs1 = 2'(rs1); cmd_rs2 = 2'(rs2);
    cmd_use_imm = ui[0]; cmd_imm = 4'(imm); cmd_flag_we = fwe[0]; rsp_ready = h == 0;
    @(posedge clk); #1 cmd_valid = 0;
    chk("cmd_ready_exec", cmd_ready, 0);
    chk("rsp_valid_exec", rsp_valid, 0);
    chk("alu_a", alu_a, 8'(a));
    chk("alu_b", alu_b, 8'(b));
    chk("alu_sel", alu_sel, 8'(op));
    @(posedge clk); #1;
    m_reg[rd] = ey;
    if (fwe != 0) m_flags = ef;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, 8'(ey));
    chk("rsp_flags", rsp_flags, 8'(ef));
    chk("flags_q", flags_q, 8'(m_flags));
    for (int i = 0; i < h; i++) begin
      hd = 4'($urandom);
      cmd_valid = 1; cmd_op = 2'($urandom); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
      cmd_use_imm = 1; cmd_imm = hd; cmd_flag_we = 1;
      @(posedge clk); #1 cmd_valid = 0;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, 8'(ey));
      chk("hold_flags", rsp_flags, 8'(ef));
      chk("hold_ready", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("rsp_done", rsp_valid, 0);
    chk("back_idle", cmd_ready, 1);
  endtask
  initial begin
    m_reg = '{0, 0, 0, 0};
    m_flags = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_flags_q", flags_q, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_data", rsp_data, 0);
    run(0, 1, 0, 0, 1, 7, 1, 0);
    chk("tp_add7", rsp_data, 7);
    run(0, 2, 1, 0, 1, 1, 1, 0);
    chk("tp_ovf_flags", flags_q, 8'h5);
    run(1, 3, 0, 1, 0, 0, 0, 0);
    chk("tp_sub_flags", rsp_flags, 8'h6);
    chk("tp_sub_flags_q", flags_q, 8'h5);
    run(0, 1, 1, 0, 1, 9, 1, 0);
    chk("tp_wrap_flags", rsp_flags, 8'ha);
    run(2, 0, 2, 0, 1, 15, 1, 0);
    chk("tp_and", rsp_data, 8);
    run(0, 3, 2, 0, 1, 3, 0, 5);
    run(3, 3, 3, 0, 1, 0, 0, 0);
    run(3, 2, 2, 0, 1, 0, 0, 0);
    // Reset in the middle of EXEC abandons the command.
    @(negedge clk);
    cmd_valid = 1; cmd_op = 0; cmd_rd = 2; cmd_rs1 = 0; cmd_use_imm = 1; cmd_imm = 5; cmd_flag_we = 1;
    @(posedge clk); #1 cmd_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    m_reg = '{0, 0, 0, 0};
    m_flags = 0;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_flags_q", flags_q, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_alu_b", alu_b, 0);
    run(3, 2, 2, 0, 1, 0, 0, 0);
    chk("mid_rst_r2", rsp_data, 0);
    for (int n = 0; n < 60; n++)
      run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
          $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    for (int r = 0; r < 4; r++) run(3, r, r, 0, 1, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
